// File: rtl/nios2_debug_ocimem.sv
// nios2_debug_ocimem
// Debug on-chip memory controller. One single-port 32-bit RAM is shared by
// JTAG host accesses (jdo bus + take_* strobes from the sysclk stage) and a
// CPU-side Avalon-MM slave. JTAG read results go out on MonDReg.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   jdo                      JTAG data, valid only in a strobe cycle
//   take_action_ocimem_a     address load (jdo[17] = read after load)
//   take_no_action_ocimem_a  streaming read
//   take_action_ocimem_b     streaming write of jdo[34:3]
//   avs_*                    CPU Avalon-MM slave (word addressed)
//   MonDReg, MonAReg         JTAG data / address registers
//   monitor_ready            no JTAG operation pending
//   monitor_error            sticky overrun flag, cleared by an address load
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | arbitrate: pending JTAG op first, then CPU write, then CPU read
// J_WR   | JTAG write of pending data to RAM[MonAReg]
// J_RD   | RAM address driven from MonAReg
// J_CAP  | RAM output captured into MonDReg
// C_WR   | byte-masked CPU write, waitrequest released
// C_RD   | RAM address driven from avs_address
// C_CAP  | RAM output presented on avs_readdata, waitrequest released
module nios2_debug_ocimem #(
  parameter int ADDR_W   = 8,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_J_WR, S_J_RD, S_J_CAP, S_C_WR, S_C_RD, S_C_CAP
  } state_t;

  state_t state, state_nxt;

  logic        pend_valid;
  logic        pend_write;
  logic        pend_inc;
  logic [31:0] pend_data;

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] ram_q;
  logic [31:0] ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]  ram_be;
  logic        ram_we;

  logic accept, take_a, take_b, take_n, new_op, dropped, op_done;

  // jdo bits outside the address/flag/data fields carry nothing for us
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Strobe acceptance: one-deep pending slot, fixed priority a > b > n.
  assign accept  = !pend_valid;
  assign take_a  = take_action_ocimem_a && accept;
  assign take_b  = take_action_ocimem_b && accept && !take_action_ocimem_a;
  assign take_n  = take_no_action_ocimem_a && accept && !take_action_ocimem_a
                   && !take_action_ocimem_b;
  assign new_op  = take_b || take_n || (take_a && jdo[17]);
  assign dropped = (take_action_ocimem_a && !accept)
                || (take_action_ocimem_b && (!accept || take_action_ocimem_a))
                || (take_no_action_ocimem_a && (!accept || take_action_ocimem_a
                                                || take_action_ocimem_b));
  assign op_done = (state == S_J_WR) || (state == S_J_CAP);

  assign monitor_ready = !pend_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pend_valid    <= 1'b0;
      pend_write    <= 1'b0;
      pend_inc      <= 1'b0;
      pend_data     <= '0;
      MonDReg       <= '0;
      MonAReg       <= '0;
      monitor_error <= 1'b0;
    end else begin
      state <= state_nxt;

      if (op_done) pend_valid <= 1'b0;

      if (take_a && jdo[17]) begin
        pend_valid <= 1'b1;
        pend_write <= 1'b0;
        pend_inc   <= 1'b0;
      end else if (take_b) begin
        pend_valid <= 1'b1;
        pend_write <= 1'b1;
        pend_inc   <= AUTO_INC;
        pend_data  <= jdo[34:3];
      end else if (take_n) begin
        pend_valid <= 1'b1;
        pend_write <= 1'b0;
        pend_inc   <= AUTO_INC;
      end

      if (take_a) begin
        MonAReg <= jdo[17+ADDR_W:18];
      end else if (op_done && pend_inc) begin
        MonAReg <= MonAReg + ADDR_W'(1);
      end

      if (state == S_J_CAP) MonDReg <= ram_q;

      // a losing strobe sets the flag even when the winner is an address load
      if (take_a)  monitor_error <= 1'b0;
      if (dropped) monitor_error <= 1'b1;
    end
  end

  always_comb begin
    state_nxt       = state;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    case (state)
      S_IDLE: begin
        if (pend_valid && pend_write)   state_nxt = S_J_WR;
        else if (pend_valid)            state_nxt = S_J_RD;
        // an op being accepted this cycle still outranks a waiting CPU request
        else if (new_op)                state_nxt = S_IDLE;
        else if (avs_write)             state_nxt = S_C_WR;
        else if (avs_read)              state_nxt = S_C_RD;
      end
      S_J_WR:  state_nxt = S_IDLE;
      S_J_RD:  state_nxt = S_J_CAP;
      S_J_CAP: state_nxt = S_IDLE;
      S_C_WR: begin
        avs_waitrequest = 1'b0;
        state_nxt       = S_IDLE;
      end
      S_C_RD:  state_nxt = S_C_CAP;
      S_C_CAP: begin
        avs_waitrequest = 1'b0;
        avs_readdata    = ram_q;
        state_nxt       = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = pend_data;
    ram_addr  = avs_address;
    case (state)
      S_J_WR: begin
        ram_we   = 1'b1;
        ram_be   = 4'hF;
        ram_addr = MonAReg;
      end
      S_J_RD: ram_addr = MonAReg;
      S_C_WR: begin
        ram_we    = 1'b1;
        ram_be    = avs_byteenable;
        ram_wdata = avs_writedata;
      end
      default: ram_we = 1'b0;
    endcase
    // an in-flight write must not land on the reset edge
    if (reset) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    ram_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_nios2_debug_ocimem.sv
// Scoreboard bench for nios2_debug_ocimem (ADDR_W=8, AUTO_INC=1).
// Stimulus pushes expected CPU read data / JTAG completions into queues; a
// monitor pops and compares when the DUT completes a CPU read or raises
// monitor_ready.
module tb_nios2_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready;
  logic        monitor_error;

  nios2_debug_ocimem #(.ADDR_W(8), .AUTO_INC(1'b1)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        chk_d;
    logic [31:0] d;
    logic [7:0]  a;
    int          lat;   // strobe-to-ready cycles, <0 skips timing checks
    int          low;   // cycles monitor_ready is low
    int          t0;
  } jexp_t;

  jexp_t       jq[$];
  logic [31:0] cpu_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic ready_d = 1'b1;
  int fall_cyc = 0;
  jexp_t je;
  logic [31:0] ce;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (avs_read && !avs_waitrequest) begin
        if (cpu_q.size() == 0) begin
          timeout_fail("cpu_unexpected_read");
        end else begin
          ce = cpu_q.pop_front();
          check("cpu_rdata", avs_readdata, ce);
        end
      end
      if (!monitor_ready && ready_d) fall_cyc = cyc;
      if (monitor_ready && !ready_d) begin
        if (jq.size() == 0) begin
          timeout_fail("jtag_unexpected_completion");
        end else begin
          je = jq.pop_front();
          check("jtag_MonAReg", {24'h0, MonAReg}, {24'h0, je.a});
          if (je.chk_d) check("jtag_MonDReg", MonDReg, je.d);
          if (je.lat >= 0) begin
            check("jtag_latency", cyc - je.t0, je.lat);
            check("jtag_ready_low", cyc - fall_cyc, je.low);
          end
        end
      end
      ready_d = monitor_ready;
    end
  end

  function automatic logic [37:0] j_addr(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[25:18] = a;
    j[17]    = rd;
    j[30]    = 1'b1;   // above the address field, must be ignored
    return j;
  endfunction

  function automatic logic [37:0] j_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic pulse(input logic a, input logic b, input logic n,
                       input logic [37:0] j, output int t);
    jdo = j;
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = n;
    t = cyc;
    @(posedge clk); #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = 38'h2A_5555_AAAA;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (monitor_ready) break;
      n++;
      if (n > 50) begin timeout_fail(name); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      n++;
      if (n > 50) begin timeout_fail(name); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    wait_accept("cpu_write");
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp);
    cpu_q.push_back(exp);
    avs_address = a; avs_read = 1'b1;
    wait_accept("cpu_read");
    avs_read = 1'b0;
  endtask

  task automatic load(input logic [7:0] a);
    int t;
    pulse(1'b1, 1'b0, 1'b0, j_addr(a, 1'b0), t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_MonAReg", {24'h0, MonAReg}, 32'h0);
    check("rst_ready", {31'h0, monitor_ready}, 32'h1);
    check("rst_error", {31'h0, monitor_error}, 32'h0);
    check("rst_waitreq", {31'h0, avs_waitrequest}, 32'h1);
    check("rst_rdata", avs_readdata, 32'h0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // load and read
    cpu_write(8'h10, 32'hDEADBEEF, 4'hF);
    pulse(1'b1, 1'b0, 1'b0, j_addr(8'h10, 1'b1), t);
    jq.push_back('{1'b1, 32'hDEADBEEF, 8'h10, 4, 3, t});
    wait_idle("load_read");

    // streaming write with wrap
    load(8'hFE);
    @(negedge clk);
    check("load_MonAReg", {24'h0, MonAReg}, 32'hFE);
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) begin
      pulse(1'b0, 1'b1, 1'b0, j_data(32'(i)), t);
      jq.push_back('{1'b0, 32'h0, 8'(8'hFE + i), 3, 2, t});
      repeat (4) @(posedge clk);
      #1;
    end
    cpu_read(8'hFE, 32'h1);
    cpu_read(8'hFF, 32'h2);
    cpu_read(8'h00, 32'h3);
    @(negedge clk);
    check("wrap_MonAReg", {24'h0, MonAReg}, 32'h01);
    @(posedge clk); #1;

    // overrun: write accepted, following streaming read dropped
    load(8'h30);
    pulse(1'b0, 1'b1, 1'b0, j_data(32'h12345678), t);
    jq.push_back('{1'b0, 32'h0, 8'h31, 3, 2, t});
    pulse(1'b0, 1'b0, 1'b1, 38'h0, t);
    wait_idle("overrun");
    @(negedge clk);
    check("overrun_error", {31'h0, monitor_error}, 32'h1);
    check("overrun_MonAReg", {24'h0, MonAReg}, 32'h31);
    @(posedge clk); #1;
    cpu_read(8'h30, 32'h12345678);
    load(8'h40);
    @(negedge clk);
    check("load_clears_error", {31'h0, monitor_error}, 32'h0);
    @(posedge clk); #1;

    // simultaneous a + b: address load wins, write dropped
    pulse(1'b1, 1'b1, 1'b0, j_addr(8'h50, 1'b0), t);
    @(negedge clk);
    check("simul_error", {31'h0, monitor_error}, 32'h1);
    check("simul_MonAReg", {24'h0, MonAReg}, 32'h50);
    check("simul_ready", {31'h0, monitor_ready}, 32'h1);
    @(posedge clk); #1;

    // arbitration: CPU read and JTAG write to 0x20 start together
    cpu_write(8'h20, 32'h0, 4'hF);
    load(8'h20);
    fork
      begin
        pulse(1'b0, 1'b1, 1'b0, j_data(32'h55AA55AA), t);
        jq.push_back('{1'b0, 32'h0, 8'h21, 3, 2, t});
      end
      cpu_read(8'h20, 32'h55AA55AA);
    join
    wait_idle("arb");

    // byte enables
    cpu_write(8'h05, 32'h11223344, 4'hF);
    cpu_write(8'h05, 32'hAABBCCDD, 4'b0101);
    load(8'h05);
    pulse(1'b0, 1'b0, 1'b1, 38'h0, t);
    jq.push_back('{1'b1, 32'h11BB33DD, 8'h06, 4, 3, t});
    wait_idle("byteen");
    cpu_read(8'h05, 32'h11BB33DD);

    // reset mid-operation
    cpu_write(8'h60, 32'hCAFEF00D, 4'hF);
    load(8'h60);
    pulse(1'b0, 1'b1, 1'b0, j_data(32'hBAD0BAD0), t);
    jq.push_back('{1'b1, 32'h0, 8'h00, -1, -1, t});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'h0, monitor_ready}, 32'h1);
    check("midrst_error", {31'h0, monitor_error}, 32'h0);
    check("midrst_waitreq", {31'h0, avs_waitrequest}, 32'h1);
    check("midrst_rdata", avs_readdata, 32'h0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    cpu_read(8'h60, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("jtag_queue_empty", jq.size(), 32'h0);
    check("cpu_queue_empty", cpu_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
